// File: rtl/prea_conv_stream.sv
// Winograd F(2x2,3x3) input transform U = B^T*d*B, fed one 4-pixel row per beat.
// Optional macro PREA_SAT_EN: clamp each U element to OUT_W bits instead of wrapping.
module prea_conv_stream #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:3][DATA_W-1:0]     row_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:3][0:3][OUT_W-1:0] tile_out,
    output logic [1:0]                 row_idx
);
    localparam int H_W = DATA_W + 1;
    localparam int U_W = DATA_W + 2;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        CLOSE   = 1'b1
    } phase_t;

`ifdef PREA_SAT_EN
    localparam int EXT_W = (OUT_W > U_W) ? OUT_W : U_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic [OUT_W-1:0] fit_elem(input logic signed [U_W-1:0] v);
        logic signed [EXT_W-1:0] ext;
        ext = EXT_W'(v);
        if (ext > SAT_MAX) begin
            fit_elem = OUT_W'(SAT_MAX);
        end else if (ext < SAT_MIN) begin
            fit_elem = OUT_W'(SAT_MIN);
        end else begin
            fit_elem = OUT_W'(ext);
        end
    endfunction
`else
    // Signed size cast: sign-extends when OUT_W is wide, keeps the low bits otherwise.
    function automatic logic [OUT_W-1:0] fit_elem(input logic signed [U_W-1:0] v);
        fit_elem = OUT_W'(v);
    endfunction
`endif

    logic signed [DATA_W-1:0]   px_s    [0:3];
    logic signed [H_W-1:0]      h_new_s [0:3];
    logic signed [H_W-1:0]      h_r     [0:2][0:3];
    logic signed [U_W-1:0]      u_s     [0:3][0:3];
    logic [0:3][0:3][OUT_W-1:0] u_fit_s;
    logic [0:3][0:3][OUT_W-1:0] tile_r;
    logic [1:0]                 row_idx_r;
    logic                       out_valid_r;
    phase_t                     phase_s;
    logic                       in_ready_s;
    logic                       accept_s;
    logic                       load_s;

    // Handshake: the closing row may only enter when the output slot is free or draining
    always_comb begin
        phase_s    = (row_idx_r == 2'd3) ? CLOSE : COLLECT;
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            case (phase_s)
                COLLECT: in_ready_s = 1'b1;
                CLOSE:   in_ready_s = ~out_valid_r | out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
        accept_s = in_valid & in_ready_s;
        load_s   = accept_s & (phase_s == CLOSE);
    end

    // Horizontal pass on the incoming row, then vertical pass with the live row as h[3]
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            px_s[j] = row_in[j];
        end
        h_new_s[0] = H_W'(px_s[0]) - H_W'(px_s[2]);
        h_new_s[1] = H_W'(px_s[1]) + H_W'(px_s[2]);
        h_new_s[2] = H_W'(px_s[2]) - H_W'(px_s[1]);
        h_new_s[3] = H_W'(px_s[1]) - H_W'(px_s[3]);
        u_fit_s = '0;
        for (int j = 0; j < 4; j++) begin
            u_s[0][j] = U_W'(h_r[0][j]) - U_W'(h_r[2][j]);
            u_s[1][j] = U_W'(h_r[1][j]) + U_W'(h_r[2][j]);
            u_s[2][j] = U_W'(h_r[2][j]) - U_W'(h_r[1][j]);
            u_s[3][j] = U_W'(h_r[1][j]) - U_W'(h_new_s[j]);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                u_fit_s[i][j] = fit_elem(u_s[i][j]);
            end
        end
    end

    // Row buffer, row counter and output tile register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_idx_r   <= 2'd0;
            out_valid_r <= 1'b0;
            tile_r      <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int j = 0; j < 4; j++) begin
                    h_r[r][j] <= '0;
                end
            end
        end else begin
            if (flush) begin
                row_idx_r <= 2'd0;
                for (int r = 0; r < 3; r++) begin
                    for (int j = 0; j < 4; j++) begin
                        h_r[r][j] <= '0;
                    end
                end
            end else if (accept_s && (phase_s == COLLECT)) begin
                for (int r = 0; r < 3; r++) begin
                    if (row_idx_r == 2'(r)) begin
                        for (int j = 0; j < 4; j++) begin
                            h_r[r][j] <= h_new_s[j];
                        end
                    end
                end
                row_idx_r <= row_idx_r + 2'd1;
            end else if (load_s) begin
                row_idx_r <= 2'd0;
            end else begin
                row_idx_r <= row_idx_r;
            end

            // A load on the same edge as a drain keeps out_valid high with the new tile
            if (load_s) begin
                tile_r      <= u_fit_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= out_valid_r & ~out_ready;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign tile_out  = tile_r;
    assign row_idx   = row_idx_r;

endmodule

// File: tb/tb_prea_conv_stream.sv
// Scoreboard bench for prea_conv_stream: stimulus pushes expected tiles, monitors pop and compare.
module tb_prea_conv_stream;
    typedef logic [0:3][0:3][17:0] tile_t;
    typedef logic [0:3][0:3][7:0]  tile8_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:3][15:0] row_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    tile_t       tile_out;
    logic [1:0]  row_idx;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [0:3][7:0] s_row_in;
    logic        s_flush;
    logic        s_out_valid;
    logic        s_out_ready;
    tile8_t      s_tile_out;
    logic [1:0]  s_row_idx;

    int     n_cmp = 0;
    int     n_err = 0;
    tile_t  exp_q[$];
    tile8_t s_q[$];
    int     mdl_d[4][4];
    int     mdl_cnt = 0;
    bit     hand_next = 1'b0;
    int     hand_u[4][4] = '{'{0, -16, 0, 0}, '{-4, 34, 2, -4}, '{0, 8, 0, 0}, '{0, -16, 0, 0}};

    prea_conv_stream #(.DATA_W(16), .OUT_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .row_in(row_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .tile_out(tile_out), .row_idx(row_idx)
    );

    prea_conv_stream #(.DATA_W(8), .OUT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .row_in(s_row_in), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .tile_out(s_tile_out), .row_idx(s_row_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic tile_t pack_tile(input int u[4][4]);
        tile_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[i][j] = 18'(u[i][j]);
        return r;
    endfunction

    // Reference: explicit matrix products U = BT * d * BT^T
    function automatic tile_t ref_tile(input int d[4][4]);
        int bt[4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
        int t[4][4];
        int u[4][4];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) t[i][j] += bt[i][k] * d[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                u[i][j] = 0;
                for (int k = 0; k < 4; k++) u[i][j] += t[i][k] * bt[j][k];
            end
        return pack_tile(u);
    endfunction

    task automatic model_row(input int a, input int b, input int c, input int d);
        mdl_d[mdl_cnt] = '{a, b, c, d};
        mdl_cnt++;
        if (mdl_cnt == 4) begin
            if (hand_next) begin
                exp_q.push_back(pack_tile(hand_u));
                hand_next = 1'b0;
            end else begin
                exp_q.push_back(ref_tile(mdl_d));
            end
            mdl_cnt = 0;
        end
    endtask

    task automatic send_row(input int a, input int b, input int c, input int d, output int waited);
        waited = 0;
        row_in[0] = 16'(a);
        row_in[1] = 16'(b);
        row_in[2] = 16'(c);
        row_in[3] = 16'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (waited < 40) model_row(a, b, c, d);
    endtask

    // Main-instance monitor: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tile: got %h required none", tile_out);
            end else begin
                check("tile", tile_out, exp_q.pop_front());
            end
        end
    end

    // Narrow-instance monitor
    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_sat_tile: got %h required none", s_tile_out);
            end else begin
                check("sat_tile", s_tile_out, s_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tile8_t st;
        rst_n = 1'b0; in_valid = 1'b0; row_in = '0; flush = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_row_in = '0; s_flush = 1'b0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_tile", tile_out, 0);
        check("rst_row_idx", row_idx, 0);
        rst_n = 1'b1;

        // Basic tile with hand-computed result
        hand_next = 1'b1;
        send_row(1, 2, 3, 4, w);
        send_row(5, 6, 7, 8, w);
        check("row_idx_2", row_idx, 2);
        send_row(9, 10, 11, 12, w);
        check("pre_out_valid", out_valid, 0);
        send_row(13, 14, 15, 16, w);
        check("latency_out_valid", out_valid, 1);
        check("row_idx_wrap", row_idx, 0);
        @(posedge clk); #1;

        // Backpressure: tile A held, rows 5-7 accepted, row 8 stalls
        out_ready = 1'b0;
        send_row(32767, -32768, -32768, 32767, w);
        send_row(-32768, 32767, 32767, -32768, w);
        send_row(32767, 32767, -32768, -32768, w);
        send_row(-32768, -32768, 32767, 32767, w);
        send_row(100, -200, 300, -400, w);
        send_row(-5, 6, -7, 8, w);
        send_row(0, 1000, -1000, 0, w);
        check("bp_row_idx", row_idx, 3);
        row_in[0] = 16'sd11; row_in[1] = -16'sd22; row_in[2] = 16'sd33; row_in[3] = -16'sd44;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold", tile_out, exp_q[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_row(11, -22, 33, -44);
        check("bp_tile2_valid", out_valid, 1);
        @(posedge clk); #1;

        // Flush: partial tile and the concurrent row are dropped
        send_row(999, 888, 777, 666, w);
        send_row(-999, -888, -777, -666, w);
        row_in[0] = 16'sd500; row_in[1] = 16'sd500; row_in[2] = 16'sd500; row_in[3] = 16'sd500;
        in_valid = 1'b1;
        flush = 1'b1;
        mdl_cnt = 0;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_row_idx", row_idx, 0);
        send_row(3, 1, 4, 1, w);
        send_row(5, 9, 2, 6, w);
        send_row(-5, 3, -5, 8, w);
        send_row(9, -7, 9, 3, w);
        @(posedge clk); #1;

        // Simultaneous drain and load, with back-to-back tiles
        send_row(1, -1, 2, -2, w);
        send_row(7, 0, -7, 0, w);
        send_row(12, 34, 56, 78, w);
        send_row(-12, -34, -56, -78, w);
        out_ready = 1'b0;
        send_row(4, 3, 2, 1, w);
        check("b2b_no_wait", w, 0);
        send_row(8, 7, 6, 5, w);
        send_row(-1, -2, -3, -4, w);
        out_ready = 1'b1;
        send_row(20, -20, 40, -40, w);
        check("drain_load_valid", out_valid, 1);
        @(posedge clk); #1;

        // Mid-operation reset with a pending tile and partial rows
        out_ready = 1'b0;
        send_row(2, 4, 6, 8, w);
        send_row(1, 3, 5, 7, w);
        send_row(9, 8, 7, 6, w);
        send_row(5, 4, 3, 2, w);
        send_row(1000, 2000, 3000, 4000, w);
        send_row(-1000, 2000, -3000, 4000, w);
        send_row(300, 300, 300, 300, w);
        check("pre_reset_pending", exp_q.size(), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_row_idx", row_idx, 0);
        check("mrst_tile", tile_out, 0);
        exp_q.delete();
        mdl_cnt = 0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_row(6, 5, 4, 3, w);
        send_row(2, 1, 0, -1, w);
        send_row(-2, -3, -4, -5, w);
        send_row(7, 7, 7, 7, w);
        @(posedge clk); #1;

        // Narrow instance: 127s overflow U[1][1]
        st = '0;
`ifdef PREA_SAT_EN
        st[1][1] = 8'h7F;
`else
        st[1][1] = 8'hFC;
`endif
        s_row_in[0] = 8'sd127; s_row_in[1] = 8'sd127; s_row_in[2] = 8'sd127; s_row_in[3] = 8'sd127;
        s_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sat_in_ready", s_in_ready, 1);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        s_q.push_back(st);

        repeat (5) @(posedge clk);
        #1;
        check("main_q_drained", exp_q.size(), 0);
        check("sat_q_drained", s_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
